// File: rtl/vote_session_ctrl.sv
// Election session FSM plus round-robin booth arbiter for the tally datapath.
// Inputs are sampled once, then decided and registered on the following edge.
module vote_session_ctrl #(
  parameter int N_BOOTHS = 4,
  parameter int CNT_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  open_req,
  input  logic                  close_req,
  input  logic                  clear_req,
  input  logic [N_BOOTHS-1:0]   booth_req,
  input  logic [4*N_BOOTHS-1:0] booth_vote,
  output logic [N_BOOTHS-1:0]   booth_ack,
  output logic [N_BOOTHS-1:0]   booth_err,
  output logic                  tally_inc,
  output logic [1:0]            tally_sel,
  output logic                  tally_clr,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      total
);

  localparam int PW = (N_BOOTHS > 1) ? $clog2(N_BOOTHS) : 1;
  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_OPEN   = 2'b01;
  localparam logic [1:0] S_CLOSED = 2'b10;

  logic                  open_q, close_q, clear_q;
  logic [N_BOOTHS-1:0]   req_q;
  logic [4*N_BOOTHS-1:0] vote_q;
  logic [N_BOOTHS-1:0]   armed_q, armed_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [N_BOOTHS-1:0]   ack_q, ack_d;
  logic [N_BOOTHS-1:0]   err_q, err_d;
  logic                  inc_q, inc_d;
  logic [1:0]            sel_q, sel_d;
  logic                  clr_q, clr_d;

  logic [N_BOOTHS-1:0]   elig;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;
  logic [3:0]            gv;
  logic [1:0]            gv_enc;
  logic                  accept;

  function automatic logic [PW-1:0] wrap(input int v);
    int w;
    w = (v >= N_BOOTHS) ? v - N_BOOTHS : v;
    return w[PW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q  <= 1'b0;
      close_q <= 1'b0;
      clear_q <= 1'b0;
      req_q   <= '0;
      vote_q  <= '0;
      armed_q <= '1;
      ptr_q   <= '0;
      state_q <= S_IDLE;
      total_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      inc_q   <= 1'b0;
      sel_q   <= 2'b00;
      clr_q   <= 1'b0;
    end else begin
      open_q  <= open_req;
      close_q <= close_req;
      clear_q <= clear_req;
      req_q   <= booth_req;
      vote_q  <= booth_vote;
      armed_q <= armed_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
      total_q <= total_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      sel_q   <= sel_d;
      clr_q   <= clr_d;
    end
  end

  // Clear wins over close, close over open; 2'b11 falls back to IDLE.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (clear_q && (state_q == S_IDLE || state_q == S_CLOSED)) begin
      state_d = S_IDLE;
      clr_d   = 1'b1;
    end else if (close_q && state_q == S_OPEN) begin
      state_d = S_CLOSED;
    end else if (open_q &&
                 (state_q == S_IDLE || state_q == S_CLOSED)) begin
      state_d = S_OPEN;
    end else if (state_q == 2'b11) begin
      state_d = S_IDLE;
    end
  end

  // Reverse scan so the lowest offset from the pointer wins.
  always_comb begin
    elig    = req_q & armed_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_BOOTHS - 1; i >= 0; i--) begin
      if (elig[wrap(int'(ptr_q) + i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap(int'(ptr_q) + i);
      end
    end
  end

  always_comb begin
    gv = vote_q[{gnt_idx, 2'b00} +: 4];
    case (gv)
      4'b0001: gv_enc = 2'd0;
      4'b0010: gv_enc = 2'd1;
      4'b0100: gv_enc = 2'd2;
      4'b1000: gv_enc = 2'd3;
      default: gv_enc = 2'd0;
    endcase
  end

  always_comb begin
    accept  = gnt_vld && (state_q == S_OPEN) && $onehot(gv)
              && (total_q != '1);
    ack_d   = '0;
    err_d   = '0;
    inc_d   = accept;
    sel_d   = accept ? gv_enc : 2'b00;
    armed_d = armed_q | ~req_q;
    ptr_d   = ptr_q;
    if (gnt_vld) begin
      if (accept) ack_d[gnt_idx] = 1'b1;
      else        err_d[gnt_idx] = 1'b1;
      armed_d[gnt_idx] = 1'b0;
      ptr_d = wrap(int'(gnt_idx) + 1);
    end
    if (clr_d)       total_d = '0;
    else if (accept) total_d = total_q + CNT_W'(1);
    else             total_d = total_q;
  end

  assign booth_ack = ack_q;
  assign booth_err = err_q;
  assign tally_inc = inc_q;
  assign tally_sel = sel_q;
  assign tally_clr = clr_q;
  assign state     = state_q;
  assign total     = total_q;

endmodule
